ddma_mem_arbiter: RTL and testbench
===================================

# ddma_mem_arbiter

Round-robin arbiter that shares the DDMA's single memory port between the receive engine (network to memory) and the send engine (memory to network). It sequences ownership of the bus, muxes address, data and byte-enables onto the memory interface, and routes read data back to the requester that issued the read. It sits between the two DDMA engine state machines and the `interface_memory` port.

## Interface

**Parameters**
- `MEMORY_BUS_WIDTH`, 32: data width in bits; a multiple of 8.
- `ADDR_WIDTH`, 32: address width.
- `MAX_BURST`, 16: maximum consecutive locked grants while the other side waits; ≥1.
- `READ_LATENCY`, 1: cycles from an accepted read to `mem_data_out` valid; ≥1.

**Ports**
- `clock`, in, 1: single clock. Everything is posedge.
- `reset`, in, 1: synchronous, active-high.
- `recv_req`, in, 1: receive engine requests a bus transfer this cycle.
- `recv_lock`, in, 1: receive engine asks to keep ownership after this transfer (burst).
- `recv_addr`, in, `ADDR_WIDTH`: word address.
- `recv_wb`, in, `MEMORY_BUS_WIDTH/8`: byte write enables; 0 means read.
- `recv_data`, in, `MEMORY_BUS_WIDTH`: write data.
- `recv_gnt`, out, 1: transfer accepted this cycle.
- `recv_rdata`, out, `MEMORY_BUS_WIDTH`: read data.
- `recv_rvalid`, out, 1: `recv_rdata` valid.
- `send_req`, `send_lock`, `send_addr`, `send_wb`, `send_data`, `send_gnt`, `send_rdata`, `send_rvalid`: same as the `recv_*` set, for the send engine.
- `mem_enable_in`, out, 1: memory access strobe.
- `mem_addr_in`, out, `ADDR_WIDTH`: memory address.
- `mem_wb_in`, out, `MEMORY_BUS_WIDTH/8`: byte write enables.
- `mem_data_in`, out, `MEMORY_BUS_WIDTH`: write data.
- `mem_data_out`, in, `MEMORY_BUS_WIDTH`: read data from memory.
- `owner`, out, 2: current state (0 IDLE, 1 RECV, 2 SEND), for debug and irq logic.

## Operation

**States:** `A_IDLE`, `A_RECV`, `A_SEND`. State is registered.

**Grants**
- `recv_gnt = (state==A_RECV) & recv_req`. `send_gnt` is symmetric.
- The memory is driven from the granted requester's `addr`/`wb`/`data`, and `mem_enable_in` equals the OR of the two grants.
- When no grant is active, every `mem_*` output is 0.

**Leaving `A_IDLE`**
- Only `recv_req` is high: go to `A_RECV`.
- Only `send_req` is high: go to `A_SEND`.
- Both are high: grant the side that is not `last_owner`.

**Inside an owner state** (owner X, other side Y)
- Keep X while all of the following hold:
  - `X_req` is high;
  - either `X_lock` is high or `Y_req` is low;
  - `burst_cnt < MAX_BURST`, or `Y_req` is low.
- Otherwise, hand over:
  - to Y if `Y_req` is high, with no idle bubble;
  - else to `A_IDLE`.
- `burst_cnt` increments on each grant, saturates at `MAX_BURST`, and clears on every change of state.
- `last_owner` updates to X when leaving X.
- Without lock, simultaneous requests alternate word by word.

**Read return**
- An accepted transfer with `wb == 0` pushes a tag {valid, owner} into a `READ_LATENCY`-deep shift register.
- On the tag's output stage, the matching `*_rvalid` is asserted and `*_rdata` is driven from `mem_data_out`.
- `*_rdata` is 0 when its `*_rvalid` is low.
- Writes push an invalid tag.

## Timing

**Reset values**
- state `A_IDLE`, `last_owner` SEND (so RECV wins the first tie), `burst_cnt` 0.
- Tag pipe all invalid.
- All outputs 0.

**Arbitration latency**
- From `A_IDLE`, a request raised in cycle n gets its grant in cycle n+1.
- Handovers between owners take effect the next cycle, with no gap.

**Requester rule**
- A requester holds `req`/`addr`/`wb`/`data` stable until it sees `gnt` high.
- A transfer completes in the cycle `gnt` is high.

**Read data timing**
- A read granted in cycle n gives `rvalid` in cycle n+`READ_LATENCY`.
- Reads stay in order per requester and are never dropped or duplicated.

**Boundary cases**
- Owner drops `req` with a transfer in flight: the pending read still returns to that owner.
- `req` dropped and re-raised while still owner, with Y idle: state is held, and the grant resumes the cycle `req` is high again.
- `MAX_BURST` reached while locked and Y requesting: the grant goes to Y next cycle, even though lock is still high.
- Reset asserted mid-burst: state, counters and tag pipe clear on that edge. In-flight reads are discarded with no `rvalid`, and `mem_enable_in` is 0 in the following cycle.

## Structure

**Shared package `ddma_pkg`**
- `arbiter_state` enum, extended to `A_IDLE`/`A_RECV`/`A_SEND` as 2-bit.
- Owner tag typedef `{logic valid; logic owner;}`.
- Shared with the `ddma` engines.

**Sub-module `ddma_read_tag_pipe`**
- Parameterised shift register of `READ_LATENCY` tags.
- Has its own synchronous reset.

The arbiter FSM, burst counter and mux stay in the top module.

## Test plan

1. **Basic read latency.** Reset, then only `recv_req` with a read at 0x10, held for 3 cycles.
   - `recv_gnt` is high in cycles 1–3.
   - `mem_addr_in` is 0x10.
   - `recv_rvalid` is high in cycles 2–4.
   - `send_rvalid` is never high.
2. **Unlocked alternation.** Both requesting continuously, no lock.
   - Grants go RECV, SEND, RECV, SEND…
   - RECV gets the first grant after reset.
3. **Locked burst and preemption.** `send_lock=1`, `MAX_BURST=4`, `recv_req` high throughout.
   - Exactly 4 consecutive `send_gnt`, then `recv_gnt` in the next cycle.
4. **Write path.** RECV writes with `wb=4'hF` and data 0xDEADBEEF.
   - `mem_wb_in` is 0xF and `mem_data_in` is 0xDEADBEEF for one cycle.
   - No `rvalid` afterwards.
5. **Reset mid-burst.** Assert `reset` while SEND is mid-burst with `READ_LATENCY=3` and reads in flight.
   - All outputs 0 on the next cycle.
   - No late `rvalid`.
   - The first grant after reset goes to RECV on a tie.
6. **Interleaved read routing.** `READ_LATENCY=2`, interleaved reads from both sides.
   - Every `rvalid` goes to the issuer, in order.
   - Scoreboard check: `rdata` equals the memory model contents.

Source files
------------

// File: rtl/ddma_pkg.sv
// Types shared by the DDMA engines and the memory arbiter: arbiter state
// encoding and the read-return owner tag.
package ddma_pkg;

  typedef enum logic [1:0] {
    A_IDLE = 2'd0,
    A_RECV = 2'd1,
    A_SEND = 2'd2
  } arbiter_state;

  typedef struct packed {
    logic valid;
    logic owner;
  } owner_tag_t;

  localparam logic OWNER_RECV = 1'b0;
  localparam logic OWNER_SEND = 1'b1;

endpackage

// File: rtl/ddma_read_tag_pipe.sv
// Shift register of owner tags that tracks reads in flight so each returning
// word can be routed to the engine that issued it.
module ddma_read_tag_pipe
  import ddma_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic push_valid,
  input  logic push_owner,
  output logic pop_valid,
  output logic pop_owner
);

  owner_tag_t tag_q [DEPTH];
  owner_tag_t tag_d [DEPTH];

  always_comb begin
    tag_d[0].valid = push_valid;
    tag_d[0].owner = push_owner;
    for (int i = 1; i < DEPTH; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  assign pop_valid = tag_q[DEPTH-1].valid;
  assign pop_owner = tag_q[DEPTH-1].owner;

endmodule

// File: rtl/ddma_mem_arbiter.sv
// Round-robin owner of the DDMA memory port between the receive and send
// engines, with burst locking and read-data return routing.
module ddma_mem_arbiter
  import ddma_pkg::*;
#(
  parameter int MEMORY_BUS_WIDTH = 32,
  parameter int ADDR_WIDTH       = 32,
  parameter int MAX_BURST        = 16,
  parameter int READ_LATENCY     = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          recv_req,
  input  logic                          recv_lock,
  input  logic [ADDR_WIDTH-1:0]         recv_addr,
  input  logic [MEMORY_BUS_WIDTH/8-1:0] recv_wb,
  input  logic [MEMORY_BUS_WIDTH-1:0]   recv_data,
  output logic                          recv_gnt,
  output logic [MEMORY_BUS_WIDTH-1:0]   recv_rdata,
  output logic                          recv_rvalid,
  input  logic                          send_req,
  input  logic                          send_lock,
  input  logic [ADDR_WIDTH-1:0]         send_addr,
  input  logic [MEMORY_BUS_WIDTH/8-1:0] send_wb,
  input  logic [MEMORY_BUS_WIDTH-1:0]   send_data,
  output logic                          send_gnt,
  output logic [MEMORY_BUS_WIDTH-1:0]   send_rdata,
  output logic                          send_rvalid,
  output logic                          mem_enable_in,
  output logic [ADDR_WIDTH-1:0]         mem_addr_in,
  output logic [MEMORY_BUS_WIDTH/8-1:0] mem_wb_in,
  output logic [MEMORY_BUS_WIDTH-1:0]   mem_data_in,
  input  logic [MEMORY_BUS_WIDTH-1:0]   mem_data_out,
  output logic [1:0]                    owner
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  arbiter_state     state_q, state_d;
  logic             last_owner_q, last_owner_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [CNT_W-1:0] burst_cnt_inc;
  logic             any_gnt;
  logic             burst_full;
  logic             push_read;
  logic             pop_valid;
  logic             pop_owner;

  // Handshake: a requester holds req/addr/wb/data stable until it sees gnt;
  // the transfer completes in the cycle where req and gnt are both high.
  assign recv_gnt = (state_q == A_RECV) & recv_req;
  assign send_gnt = (state_q == A_SEND) & send_req;
  assign any_gnt  = recv_gnt | send_gnt;

  // Count includes the grant happening now, so MAX_BURST grants fit in a burst.
  assign burst_cnt_inc = (any_gnt && (burst_cnt_q != BURST_MAX)) ?
                         burst_cnt_q + CNT_W'(1) : burst_cnt_q;
  assign burst_full    = (burst_cnt_inc >= BURST_MAX);

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    case (state_q)
      A_IDLE: begin
        if (recv_req && (!send_req || (last_owner_q == OWNER_SEND))) begin
          state_d = A_RECV;
        end else if (send_req) begin
          state_d = A_SEND;
        end
      end
      // With the other side idle the owner parks, so a dropped and re-raised
      // req is granted again in the same cycle.
      A_RECV: begin
        if (send_req && (!recv_req || !recv_lock || burst_full)) begin
          state_d      = A_SEND;
          last_owner_d = OWNER_RECV;
        end
      end
      A_SEND: begin
        if (recv_req && (!send_req || !send_lock || burst_full)) begin
          state_d      = A_RECV;
          last_owner_d = OWNER_SEND;
        end
      end
      default: begin
        state_d = A_IDLE;
      end
    endcase
    burst_cnt_d = (state_d != state_q) ? '0 : burst_cnt_inc;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= A_IDLE;
      last_owner_q <= OWNER_SEND;
      burst_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

  always_comb begin
    mem_enable_in = any_gnt;
    mem_addr_in   = '0;
    mem_wb_in     = '0;
    mem_data_in   = '0;
    if (recv_gnt) begin
      mem_addr_in = recv_addr;
      mem_wb_in   = recv_wb;
      mem_data_in = recv_data;
    end else if (send_gnt) begin
      mem_addr_in = send_addr;
      mem_wb_in   = send_wb;
      mem_data_in = send_data;
    end
  end

  assign push_read = any_gnt && (mem_wb_in == '0);

  ddma_read_tag_pipe #(
    .DEPTH (READ_LATENCY)
  ) u_tag_pipe (
    .clock      (clock),
    .reset      (reset),
    .push_valid (push_read),
    .push_owner (send_gnt),
    .pop_valid  (pop_valid),
    .pop_owner  (pop_owner)
  );

  assign recv_rvalid = pop_valid && (pop_owner == OWNER_RECV);
  assign send_rvalid = pop_valid && (pop_owner == OWNER_SEND);
  assign recv_rdata  = recv_rvalid ? mem_data_out : '0;
  assign send_rdata  = send_rvalid ? mem_data_out : '0;

  assign owner = state_q;

endmodule

// File: tb/tb_ddma_mem_arbiter.sv
// Directed bench for ddma_mem_arbiter: three instances share stimulus and
// differ only in READ_LATENCY (1, 2, 3); a scoreboard checks read routing.
module tb_ddma_mem_arbiter;

  localparam int NI = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic        recv_req, recv_lock, send_req, send_lock;
  logic [31:0] recv_addr, recv_data, send_addr, send_data;
  logic [3:0]  recv_wb, send_wb;

  logic [NI-1:0]       recv_gnt_w, send_gnt_w, recv_rvalid_w, send_rvalid_w, mem_enable_w;
  logic [NI-1:0][31:0] recv_rdata_w, send_rdata_w, mem_addr_w, mem_data_w, mem_dout_w;
  logic [NI-1:0][3:0]  mem_wb_w;
  logic [NI-1:0][1:0]  owner_w;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [63:0] recv_exp_q [NI][$];
  logic [63:0] send_exp_q [NI][$];

  // clock / reset block
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int LAT = g + 1;
    logic [LAT-1:0]       rd_v;
    logic [LAT-1:0][31:0] rd_a;

    ddma_mem_arbiter #(
      .MEMORY_BUS_WIDTH (32),
      .ADDR_WIDTH       (32),
      .MAX_BURST        (4),
      .READ_LATENCY     (LAT)
    ) u_dut (
      .clock         (clock),
      .reset         (reset),
      .recv_req      (recv_req),
      .recv_lock     (recv_lock),
      .recv_addr     (recv_addr),
      .recv_wb       (recv_wb),
      .recv_data     (recv_data),
      .recv_gnt      (recv_gnt_w[g]),
      .recv_rdata    (recv_rdata_w[g]),
      .recv_rvalid   (recv_rvalid_w[g]),
      .send_req      (send_req),
      .send_lock     (send_lock),
      .send_addr     (send_addr),
      .send_wb       (send_wb),
      .send_data     (send_data),
      .send_gnt      (send_gnt_w[g]),
      .send_rdata    (send_rdata_w[g]),
      .send_rvalid   (send_rvalid_w[g]),
      .mem_enable_in (mem_enable_w[g]),
      .mem_addr_in   (mem_addr_w[g]),
      .mem_wb_in     (mem_wb_w[g]),
      .mem_data_in   (mem_data_w[g]),
      .mem_data_out  (mem_dout_w[g]),
      .owner         (owner_w[g])
    );

    // memory model: read data appears LAT cycles after the access
    always @(posedge clock) begin
      for (int i = LAT - 1; i > 0; i--) begin
        rd_v[i] <= rd_v[i-1];
        rd_a[i] <= rd_a[i-1];
      end
      rd_v[0] <= mem_enable_w[g] && (mem_wb_w[g] == 4'h0);
      rd_a[0] <= mem_addr_w[g];
    end
    assign mem_dout_w[g] = rd_v[LAT-1] ? mem_word(rd_a[LAT-1]) : 32'h0;

    // scoreboard: entries are {due cycle, expected data}
    always @(negedge clock) begin
      logic [63:0] e;
      if (recv_rvalid_w[g]) begin
        if (recv_exp_q[g].size() != 0) e = recv_exp_q[g].pop_front();
        else e = '1;
        chk($sformatf("sb_recv_l%0d", LAT), {32'(cyc), recv_rdata_w[g]}, e);
      end else begin
        chk($sformatf("sb_recv_rdata_idle_l%0d", LAT), {32'h0, recv_rdata_w[g]}, 64'h0);
      end
      if (send_rvalid_w[g]) begin
        if (send_exp_q[g].size() != 0) e = send_exp_q[g].pop_front();
        else e = '1;
        chk($sformatf("sb_send_l%0d", LAT), {32'(cyc), send_rdata_w[g]}, e);
      end else begin
        chk($sformatf("sb_send_rdata_idle_l%0d", LAT), {32'h0, send_rdata_w[g]}, 64'h0);
      end
      if (reset) begin
        recv_exp_q[g].delete();
        send_exp_q[g].delete();
      end else if (mem_enable_w[g] && (mem_wb_w[g] == 4'h0)) begin
        if (recv_gnt_w[g]) recv_exp_q[g].push_back({32'(cyc + LAT), mem_word(mem_addr_w[g])});
        if (send_gnt_w[g]) send_exp_q[g].push_back({32'(cyc + LAT), mem_word(mem_addr_w[g])});
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    for (int g = 0; g < NI; g++) begin
      chk({tag, "_mem_en"}, mem_enable_w[g], 0);
      chk({tag, "_mem_addr"}, mem_addr_w[g], 0);
      chk({tag, "_mem_wb"}, mem_wb_w[g], 0);
      chk({tag, "_mem_data"}, mem_data_w[g], 0);
      chk({tag, "_gnts"}, {recv_gnt_w[g], send_gnt_w[g]}, 0);
      chk({tag, "_rvalids"}, {recv_rvalid_w[g], send_rvalid_w[g]}, 0);
      chk({tag, "_rdatas"}, {recv_rdata_w[g], send_rdata_w[g]}, 0);
      chk({tag, "_owner"}, owner_w[g], 0);
    end
  endtask

  initial begin
    reset = 1'b1;
    recv_req = 0; recv_lock = 0; recv_addr = 0; recv_wb = 0; recv_data = 0;
    send_req = 0; send_lock = 0; send_addr = 0; send_wb = 0; send_data = 0;

    // reset state
    next_cycle();
    @(negedge clock);
    chk_all_zero("reset");
    next_cycle();

    // basic read latency, then parked owner and write path
    reset = 1'b0;
    recv_req = 1; recv_addr = 32'h10; recv_wb = 4'h0;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) recv_req = 0;
      @(negedge clock);
      chk("t1_recv_gnt", recv_gnt_w[0], (i >= 1) && (i <= 3));
      if ((i >= 1) && (i <= 3)) chk("t1_mem_addr", mem_addr_w[0], 32'h10);
      chk("t1_recv_rvalid", recv_rvalid_w[0], (i >= 2) && (i <= 4));
      chk("t1_send_rvalid", send_rvalid_w[0], 0);
      next_cycle();
    end
    @(negedge clock);
    chk("t1_owner_parked", owner_w[0], 2'd1);
    next_cycle();

    recv_req = 1; recv_wb = 4'hF; recv_data = 32'hDEADBEEF; recv_addr = 32'h44;
    @(negedge clock);
    chk("t4_recv_gnt_resume", recv_gnt_w[0], 1);
    chk("t4_mem_wb", mem_wb_w[0], 4'hF);
    chk("t4_mem_data", mem_data_w[0], 32'hDEADBEEF);
    chk("t4_mem_addr", mem_addr_w[0], 32'h44);
    next_cycle();
    recv_req = 0; recv_wb = 4'h0; recv_data = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("t4_mem_en_after", mem_enable_w[0], 0);
      chk("t4_mem_wb_after", mem_wb_w[0], 0);
      chk("t4_mem_data_after", mem_data_w[0], 0);
      for (int g = 0; g < NI; g++) chk("t4_no_rvalid", recv_rvalid_w[g], 0);
      next_cycle();
    end

    // unlocked alternation with interleaved reads
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    recv_req = 1; send_req = 1; recv_addr = 32'h20; send_addr = 32'h30;
    for (int i = 0; i < 9; i++) begin
      logic rg, sg;
      rg = (i > 0) && (i % 2 == 1);
      sg = (i > 0) && (i % 2 == 0);
      @(negedge clock);
      chk("t2_recv_gnt", recv_gnt_w[0], rg);
      chk("t2_send_gnt", send_gnt_w[0], sg);
      if (rg) chk("t2_mem_addr_recv", mem_addr_w[0], recv_addr);
      if (sg) chk("t2_mem_addr_send", mem_addr_w[0], send_addr);
      next_cycle();
      if (rg) recv_addr = recv_addr + 32'h4;
      if (sg) send_addr = send_addr + 32'h4;
    end

    // locked burst, preemption, then reset mid-burst
    reset = 1'b1;
    recv_req = 0;
    next_cycle();
    reset = 1'b0;
    send_req = 1; send_lock = 1; send_addr = 32'h40; recv_addr = 32'h50;
    for (int i = 0; i < 9; i++) begin
      logic rg, sg;
      rg = (i == 5);
      sg = ((i >= 1) && (i <= 4)) || (i >= 6);
      if (i == 1) recv_req = 1;
      if (i == 8) reset = 1'b1;
      @(negedge clock);
      chk("t3_recv_gnt", recv_gnt_w[0], rg);
      chk("t3_send_gnt", send_gnt_w[0], sg);
      next_cycle();
      if (rg) recv_addr = recv_addr + 32'h4;
      if (sg) send_addr = send_addr + 32'h4;
    end
    reset = 1'b0;
    @(negedge clock);
    chk_all_zero("t5_after_reset");
    next_cycle();
    @(negedge clock);
    chk("t5_first_gnt_recv", recv_gnt_w[0], 1);
    chk("t5_first_gnt_send", send_gnt_w[0], 0);
    for (int g = 0; g < NI; g++) chk("t5_no_late_send_rvalid", send_rvalid_w[g], 0);
    next_cycle();
    @(negedge clock);
    chk("t5_handover_send", send_gnt_w[0], 1);
    for (int g = 0; g < NI; g++) chk("t5_no_late_send_rvalid2", send_rvalid_w[g], 0);
    next_cycle();

    // drain and confirm nothing was dropped
    recv_req = 0; send_req = 0; send_lock = 0;
    for (int i = 0; i < 5; i++) next_cycle();
    @(negedge clock);
    for (int g = 0; g < NI; g++) begin
      chk("drain_recv_q", recv_exp_q[g].size(), 0);
      chk("drain_send_q", send_exp_q[g].size(), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
